// File: rtl/sc_stream_mac.sv
// Stochastic-computing MAC stage: compares LFSR streams against latched operands, counts product ones per window
// and accumulates window counts across terms. Define SC_STREAM_MAC_SAT_EN for a saturating accumulator with ovf flag.
//
// state  | meaning
// IDLE   | waiting for start; operands latched on accept
// RUN    | STREAM_LEN cycles of stochastic bit generation and ones counting
// DONE   | one-cycle done pulse with result valid
module sc_stream_mac #(
  parameter int WIDTH      = 7,
  parameter int STREAM_LEN = 127,
  parameter int CNT_W      = 7,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 last,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     rn_a,
  input  logic [WIDTH-1:0]     rn_b,
  output logic                 busy,
  output logic                 done,
`ifdef SC_STREAM_MAC_SAT_EN
  output logic                 ovf,
`endif
  output logic [ACC_WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]     a_q, b_q;
  logic                 last_q;
  logic [CNT_W-1:0]     ones_q;
  logic [CNT_W-1:0]     cyc_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] result_q;

  logic                 bit_prod;
  logic                 win_end;
  logic [CNT_W-1:0]     win_cnt;
  logic [ACC_WIDTH-1:0] sum;

  assign bit_prod = (rn_a < a_q) & (rn_b < b_q);
  assign win_end  = (cyc_q == CNT_W'(STREAM_LEN - 1));
  // Final window count includes the bit sampled on the closing edge.
  assign win_cnt  = ones_q + CNT_W'(bit_prod);

`ifdef SC_STREAM_MAC_SAT_EN
  logic [ACC_WIDTH:0] sum_ext;
  logic               add_ovf;
  logic               ovf_q;

  assign sum_ext = {1'b0, acc_q} + (ACC_WIDTH + 1)'(win_cnt);
  assign add_ovf = sum_ext[ACC_WIDTH];
  assign sum     = add_ovf ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state == S_DONE) begin
      ovf_q <= 1'b0;
    end else if (state == S_RUN && win_end && add_ovf) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign sum = acc_q + ACC_WIDTH'(win_cnt);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (win_end) state_nxt = last_q ? S_DONE : S_IDLE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      last_q   <= 1'b0;
      ones_q   <= '0;
      cyc_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            last_q <= last;
            ones_q <= '0;
            cyc_q  <= '0;
          end
        end
        S_RUN: begin
          ones_q <= win_cnt;
          cyc_q  <= cyc_q + 1'b1;
          if (win_end) begin
            if (last_q) begin
              result_q <= sum;
              acc_q    <= '0;
            end else begin
              acc_q <= sum;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_sc_stream_mac.sv
// Self-checking bench for sc_stream_mac: a 16-bit and an 8-bit accumulator instance share directed stimulus
// and are compared each cycle against a term-level model, plus hand-computed literal results.
module tb_sc_stream_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        last = 1'b0;
  logic [6:0]  a = '0, b = '0;
  logic [6:0]  rn_a, rn_b;
  logic        busy, done, busy8, done8;
  logic [15:0] result;
  logic [7:0]  result8;
`ifdef SC_STREAM_MAC_SAT_EN
  logic        ovf, ovf8;
`endif

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  sc_stream_mac #(.WIDTH(7), .STREAM_LEN(127), .CNT_W(7), .ACC_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .last(last), .a(a), .b(b),
    .rn_a(rn_a), .rn_b(rn_b), .busy(busy), .done(done),
`ifdef SC_STREAM_MAC_SAT_EN
    .ovf(ovf),
`endif
    .result(result)
  );

  sc_stream_mac #(.WIDTH(7), .STREAM_LEN(127), .CNT_W(7), .ACC_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .last(last), .a(a), .b(b),
    .rn_a(rn_a), .rn_b(rn_b), .busy(busy8), .done(done8),
`ifdef SC_STREAM_MAC_SAT_EN
    .ovf(ovf8),
`endif
    .result(result8)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Free-running 7-bit XNOR LFSRs (x^7 + x^6 + 1); all-ones is the unreachable lock-up state.
  function automatic logic [6:0] lfsr_next(input logic [6:0] s);
    return {s[5:0], ~(s[6] ^ s[5])};
  endfunction

  logic [6:0] lfsr_a = 7'h00;
  logic [6:0] lfsr_b = 7'h15;
  assign rn_a = lfsr_a;
  assign rn_b = lfsr_b;

  always @(negedge clk) begin
    lfsr_a = lfsr_next(lfsr_a);
    lfsr_b = lfsr_next(lfsr_b);
  end

  // Term-level reference: phase 0 idle, 1 streaming, 2 result pulse.
  int m_phase = 0, m_cyc = 0, m_cnt = 0;
  int m_acc = 0, m_res = 0, m_acc8 = 0, m_res8 = 0;
  int ma = 0, mb = 0;
  bit ml = 1'b0;
  bit m_ovf8 = 1'b0;

  function automatic int add8(input int acc, input int cnt);
`ifdef SC_STREAM_MAC_SAT_EN
    if (acc + cnt > 255) begin
      m_ovf8 = 1'b1;
      return 255;
    end
    return acc + cnt;
`else
    return (acc + cnt) % 256;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_acc = 0; m_res = 0; m_acc8 = 0; m_res8 = 0; m_ovf8 = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          ma = int'(a); mb = int'(b); ml = last; m_cnt = 0; m_cyc = 0; m_phase = 1;
        end
        1: begin
          if (int'(rn_a) < ma && int'(rn_b) < mb) m_cnt++;
          m_cyc++;
          if (m_cyc == 127) begin
            m_acc8 = add8(m_acc8, m_cnt);
            if (ml) begin
              m_res = (m_acc + m_cnt) % 65536; m_acc = 0;
              m_res8 = m_acc8; m_acc8 = 0;
              m_phase = 2;
            end else begin
              m_acc = m_acc + m_cnt;
              m_phase = 0;
            end
          end
        end
        default: begin
          m_phase = 0;
          m_ovf8 = 1'b0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(busy), int'(m_phase == 1));
      check("done", int'(done), int'(m_phase == 2));
      check("result", int'(result), m_res);
      check("busy8", int'(busy8), int'(m_phase == 1));
      check("done8", int'(done8), int'(m_phase == 2));
      check("result8", int'(result8), m_res8);
`ifdef SC_STREAM_MAC_SAT_EN
      check("ovf", int'(ovf), 0);
      check("ovf8", int'(ovf8), int'(m_ovf8));
`endif
    end
  end

  // Runs one term; optionally pokes start with a different operand mid-RUN and during DONE.
  task automatic term(input int ta, input int tbv, input bit tl, input bit poke);
    int n;
    @(negedge clk);
    a = 7'(ta); b = 7'(tbv); last = tl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      if (poke && n == 49) begin
        start = 1'b1; a = 7'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("busy_len", n, 127);
    check("done_at_end", int'(done), int'(tl));
    if (poke && tl) begin
      start = 1'b1; a = 7'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
        check("no_rerun", int'(busy), 0);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    rst = 1'b0;

    term(127, 127, 1'b1, 1'b0);
    check("full_scale", int'(result), 127);
    check("full_scale_model", m_res, 127);

    term(0, 100, 1'b1, 1'b0);
    check("zero_operand", int'(result), 0);
    term(64, 127, 1'b1, 1'b0);
    check("half_scale", int'(result), 64);

    term(127, 127, 1'b0, 1'b0);
    term(127, 127, 1'b1, 1'b0);
    check("two_term", int'(result), 254);
    term(0, 5, 1'b1, 1'b0);
    check("acc_cleared", int'(result), 0);

    term(127, 127, 1'b1, 1'b1);
    check("poke_ignored", int'(result), 127);

    @(negedge clk);
    a = 7'd127; b = 7'd127; last = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (59) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_run_busy", int'(busy), 0);
    term(127, 127, 1'b1, 1'b0);
    check("after_abort", int'(result), 127);

    repeat (3) term(127, 127, 1'b0, 1'b0);
    term(127, 127, 1'b1, 1'b0);
    check("four_term16", int'(result), 508);
`ifdef SC_STREAM_MAC_SAT_EN
    check("four_term8_sat", int'(result8), 255);
    check("ovf8_with_done", int'(ovf8), 1);
    @(negedge clk);
    check("ovf8_cleared", int'(ovf8), 0);
`else
    check("four_term8_wrap", int'(result8), 252);
    @(negedge clk);
`endif
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
